// File: rtl/fmadd_operand_unpacker.sv
// Unpacks the three FMA operands into {sign, exponent, hidden, fraction} and buffers them in a 2-entry FIFO.
// Optional per-operand {nan, inf, zero} classification is built when FMADD_UNPACK_CLASS_EN is defined.
module fmadd_operand_unpacker #(
    parameter int std = 31,
    parameter int exp = 7,
    parameter int man = 22
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    input  logic [std:0]   in_a,
    input  logic [std:0]   in_b,
    input  logic [std:0]   in_c,
    input  logic           in_valid,
    output logic           in_ready,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [std+1:0] out_a,
    output logic [std+1:0] out_b,
    output logic [std+1:0] out_c,
    output logic           a_sub_norm,
    output logic           a_pos_exp,
    output logic           a_neg_exp,
    output logic           b_sub_norm,
    output logic           b_pos_exp,
    output logic           b_neg_exp,
    output logic           c_zero,
    output logic [2:0]     a_class,
    output logic [2:0]     b_class,
    output logic [2:0]     c_class
);

    localparam int EW = exp + 1;
    localparam int FW = man + 1;
    localparam int OW = std + 2;
    localparam int PW = 3 * OW + 7;

    function automatic logic [OW-1:0] unpack(input logic [std:0] v);
        logic [EW-1:0] e;
        logic [FW-1:0] f;
        e = v[std-1 -: EW];
        f = v[FW-1:0];
        if (e == '0) begin
            // Subnormals take the minimum biased exponent of 1 with a clear hidden bit
            if (f == '0) unpack = {v[std], {(OW-1){1'b0}}};
            else         unpack = {v[std], EW'(1), 1'b0, f};
        end else begin
            unpack = {v[std], e, 1'b1, f};
        end
    endfunction

    // Returns {sub_norm, pos_exp, neg_exp}
    function automatic logic [2:0] exp_flags(input logic [std:0] v);
        logic [EW-1:0] e;
        logic          sub;
        logic          neg;
        e   = v[std-1 -: EW];
        sub = (e == '0);
        neg = !sub && !e[exp] && (e[exp-1:0] != '1);
        exp_flags = {sub, !sub && !neg, neg};
    endfunction

    logic [1:0]    count_q, count_d;
    logic          wr_q, wr_d;
    logic          rd_q, rd_d;
    logic          push, pop;
    logic [PW-1:0] mem_q [2];
    logic [PW-1:0] pay_in;
    logic [PW-1:0] head;

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    assign pay_in = {unpack(in_a), unpack(in_b), unpack(in_c),
                     exp_flags(in_a), exp_flags(in_b), (in_c[std-1:0] == '0)};

    always_comb begin
        count_d = count_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        if (flush) begin
            count_d = 2'd0;
            wr_d    = 1'b0;
            rd_d    = 1'b0;
        end else begin
            if (push) wr_d = ~wr_q;
            if (pop)  rd_d = ~rd_q;
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= 2'd0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= pay_in;
    end

    // Storage contents are never exposed while the FIFO is empty
    assign head = out_valid ? mem_q[rd_q] : '0;
    assign {out_a, out_b, out_c,
            a_sub_norm, a_pos_exp, a_neg_exp,
            b_sub_norm, b_pos_exp, b_neg_exp, c_zero} = head;

`ifdef FMADD_UNPACK_CLASS_EN
    // Returns {nan, inf, zero}
    function automatic logic [2:0] classify(input logic [std:0] v);
        logic [EW-1:0] e;
        logic [FW-1:0] f;
        e = v[std-1 -: EW];
        f = v[FW-1:0];
        classify = {(&e) && (f != '0), (&e) && (f == '0), (e == '0) && (f == '0)};
    endfunction

    logic [8:0] cls_q [2];

    always_ff @(posedge clk) begin
        if (push) cls_q[wr_q] <= {classify(in_a), classify(in_b), classify(in_c)};
    end

    assign {a_class, b_class, c_class} = out_valid ? cls_q[rd_q] : 9'd0;
`else
    assign a_class = 3'd0;
    assign b_class = 3'd0;
    assign c_class = 3'd0;
`endif

endmodule

// File: tb/tb_fmadd_operand_unpacker.sv
// Directed bench for fmadd_operand_unpacker: vector table plus handshake, flush and reset sequences.
module tb_fmadd_operand_unpacker;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_a, in_b, in_c;
    logic        in_ready, out_valid;
    logic [32:0] out_a, out_b, out_c;
    logic        a_sub_norm, a_pos_exp, a_neg_exp, b_sub_norm, b_pos_exp, b_neg_exp, c_zero;
    logic [2:0]  a_class, b_class, c_class;

    int n_cmp = 0;
    int n_err = 0;

`ifdef FMADD_UNPACK_CLASS_EN
    localparam bit CLS = 1'b1;
`else
    localparam bit CLS = 1'b0;
`endif

    fmadd_operand_unpacker dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_a(in_a), .in_b(in_b), .in_c(in_c),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_c(out_c),
        .a_sub_norm(a_sub_norm), .a_pos_exp(a_pos_exp), .a_neg_exp(a_neg_exp),
        .b_sub_norm(b_sub_norm), .b_pos_exp(b_pos_exp), .b_neg_exp(b_neg_exp),
        .c_zero(c_zero),
        .a_class(a_class), .b_class(b_class), .c_class(c_class)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a, b, c;
        logic [32:0] ea, eb, ec;
        logic [6:0]  fl;   // {a_sub,a_pos,a_neg,b_sub,b_pos,b_neg,c_zero}
        logic [8:0]  cl;   // {a_class,b_class,c_class}
    } vec_t;

    vec_t vt [5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic drive(input int i);
        in_a = vt[i].a;
        in_b = vt[i].b;
        in_c = vt[i].c;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_head(input int i, input string tag);
        chk({tag, ".out_valid"}, 64'(out_valid), 64'd1);
        chk({tag, ".out_a"}, 64'(out_a), 64'(vt[i].ea));
        chk({tag, ".out_b"}, 64'(out_b), 64'(vt[i].eb));
        chk({tag, ".out_c"}, 64'(out_c), 64'(vt[i].ec));
        chk({tag, ".flags"}, 64'({a_sub_norm, a_pos_exp, a_neg_exp, b_sub_norm, b_pos_exp, b_neg_exp, c_zero}),
            64'(vt[i].fl));
        chk({tag, ".class"}, 64'({a_class, b_class, c_class}), CLS ? 64'(vt[i].cl) : 64'd0);
    endtask

    initial begin
        vt[0] = '{32'h3F800000, 32'h3F000000, 32'h80000000,
                  33'h07F800000, 33'h07E800000, 33'h100000000, 7'b010_001_1, 9'b000_000_001};
        vt[1] = '{32'h00000001, 32'h80000000, 32'h00000001,
                  33'h001000001, 33'h100000000, 33'h001000001, 7'b100_100_0, 9'b000_001_000};
        vt[2] = '{32'h7FC00000, 32'hFF800000, 32'h40490FDB,
                  33'h0FFC00000, 33'h1FF800000, 33'h080C90FDB, 7'b010_010_0, 9'b100_010_000};
        vt[3] = '{32'hBF7FFFFF, 32'h00800000, 32'h807FFFFF,
                  33'h17EFFFFFF, 33'h001800000, 33'h1017FFFFF, 7'b001_001_0, 9'b000_000_000};
        vt[4] = '{32'h7F7FFFFF, 32'h007FFFFF, 32'h7F800000,
                  33'h0FEFFFFFF, 33'h0017FFFFF, 33'h0FF800000, 7'b010_100_0, 9'b000_000_010};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_c = '0;
        #12;
        chk("reset.out_valid", 64'(out_valid), 64'd0);
        chk("reset.in_ready", 64'(in_ready), 64'd1);
        chk("reset.out_a", 64'(out_a), 64'd0);
        rst = 1'b0;

        // Single transactions through an empty FIFO
        for (int i = 0; i < 5; i++) begin
            drive(i);
            in_valid = 1'b1; out_ready = 1'b1;
            step();
            in_valid = 1'b0;
            check_head(i, $sformatf("vec%0d", i));
            step();
            chk($sformatf("vec%0d.drained", i), 64'(out_valid), 64'd0);
        end

        // Backpressure: fill two, third held off, then drain in order
        out_ready = 1'b0; in_valid = 1'b1;
        drive(0); step();
        drive(1); step();
        chk("full.in_ready", 64'(in_ready), 64'd0);
        drive(2); step();
        chk("full.in_ready_held", 64'(in_ready), 64'd0);
        check_head(0, "full.head0");
        out_ready = 1'b1;
        step();
        check_head(1, "drain.head1");
        chk("drain.in_ready", 64'(in_ready), 64'd1);
        step();                           // push vec2 and pop vec1 together at count 1
        check_head(2, "pushpop.head2");
        in_valid = 1'b0;
        step();
        chk("drain.empty", 64'(out_valid), 64'd0);

        // Flush with a full FIFO and a concurrent push
        out_ready = 1'b0; in_valid = 1'b1;
        drive(3); step();
        drive(4); step();
        chk("preflush.in_ready", 64'(in_ready), 64'd0);
        flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush.out_valid", 64'(out_valid), 64'd0);
        chk("flush.in_ready", 64'(in_ready), 64'd1);
        chk("flush.out_a", 64'(out_a), 64'd0);
        step();
        chk("flush.nothing_stored", 64'(out_valid), 64'd0);

        // Asynchronous reset with an entry in flight
        drive(0); in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("midrst.pre_valid", 64'(out_valid), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("midrst.out_valid", 64'(out_valid), 64'd0);
        chk("midrst.in_ready", 64'(in_ready), 64'd1);
        chk("midrst.out_a", 64'(out_a), 64'd0);
        #1 rst = 1'b0;
        drive(2); in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check_head(2, "postrst");
        step();
        chk("postrst.drained", 64'(out_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fmadd_operand_unpacker.md
FMADD_OPERAND_UNPACKER -- requirements
Module: fmadd_operand_unpacker

Interface
REQ-001 SHALL have parameter std, default 31: MSB index of an IEEE operand (operand width std+1).
REQ-002 SHALL have parameter exp, default 7: MSB index of the exponent field (exp+1 bits).
REQ-003 SHALL have parameter man, default 22: MSB index of the stored fraction (man+1 bits).
REQ-004 SHALL have port clk  input  1: single clock; all state is updated on its rising edge.
REQ-005 SHALL have port rst  input  1: asynchronous, active-high reset.
REQ-006 SHALL have port flush  input  1: synchronous discard of all buffered entries.
REQ-007 SHALL have ports in_a, in_b, in_c  input  std+1 each: raw IEEE operands A, B, C.
REQ-008 SHALL have ports in_valid input 1 and in_ready output 1: input handshake.
REQ-009 SHALL have ports out_valid output 1 and out_ready input 1: output handshake.
REQ-010 SHALL have ports out_a, out_b, out_c  output  std+2 each: unpacked {sign, exponent, hidden, fraction}.
REQ-011 SHALL have ports a_sub_norm, a_pos_exp, a_neg_exp, b_sub_norm, b_pos_exp, b_neg_exp, c_zero  output  1 each: per-entry classification.
REQ-012 SHALL have ports a_class, b_class, c_class  output  3 each: {nan, inf, zero} flags (see Configuration).

Function
REQ-013 SHALL classify an operand as subnormal when its exponent field is all zeros (zero included).
REQ-014 SHALL unpack a normal operand as {sign, exponent, 1, fraction}.
REQ-015 SHALL unpack a nonzero subnormal as {sign, exponent=1, 0, fraction}.
REQ-016 SHALL unpack zero (exponent and fraction all zero), for A, B and C alike, as {sign, 0, 0, 0}.
REQ-017 SHALL assert x_neg_exp when not subnormal, exponent MSB is 0 and the remaining exponent bits are not all ones (exponent < bias); x_pos_exp = not subnormal and not x_neg_exp.
REQ-018 SHALL assert c_zero when in_c[std-1:0] is all zeros.
REQ-019 SHALL store unpacked data and flags in a 2-entry FIFO; count ranges 0..2.
REQ-020 SHALL drive in_ready = (count < 2), computed from registered count only.
REQ-021 SHALL push when in_valid & in_ready and pop when out_valid & out_ready; simultaneous push and pop leaves count unchanged.
REQ-022 SHALL drive out_valid = (count > 0); latency from accepted input to out_valid is exactly 1 cycle when empty.
REQ-023 SHALL hold head data stable while out_valid & !out_ready.
REQ-024 SHALL drive all data and flag outputs to zero while out_valid is low.
REQ-025 SHALL preserve strict FIFO order; read/write pointers wrap modulo 2.
REQ-026 SHALL, on flush, set count to 0 at the next edge and ignore any same-cycle push or pop.

Reset
REQ-027 SHALL, on rst assertion, immediately clear count and pointers: out_valid=0, in_ready=1, all data/flag outputs 0.
REQ-028 SHALL discard entries in flight when rst asserts mid-operation; first accept after release is a normal 1-cycle path.

Configuration
REQ-029 SHALL use macro FMADD_UNPACK_CLASS_EN: when defined, compute and buffer {nan, inf, zero} per operand (exponent all ones with fraction nonzero / zero; exponent and fraction zero).
REQ-030 SHALL, without FMADD_UNPACK_CLASS_EN, tie a_class/b_class/c_class to 0 and instantiate no class storage.

Verification
REQ-031 SHALL cover: A=0x3F800000, B=0x3F000000, C=0x80000000, out_ready=1 -> next cycle out_a=0x07F800000, a_pos_exp=1, b_neg_exp=1, out_c=0x100000000, c_zero=1.
REQ-032 SHALL cover: A=0x00000001 -> out_a=0x001000001, a_sub_norm=1, a_pos_exp=0, a_neg_exp=0.
REQ-033 SHALL cover: out_ready=0, three back-to-back pushes -> in_ready low after 2nd; 3rd held off; then out_ready=1 drains entries in order.
REQ-034 SHALL cover: count=1 with push and pop in the same cycle -> count stays 1, new entry at head next cycle.
REQ-035 SHALL cover: count=2, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, nothing stored.
REQ-036 SHALL cover, with FMADD_UNPACK_CLASS_EN: A=0x7FC00000, B=0xFF800000 -> a_class=3'b100, b_class=3'b010; without macro both 0.
